// File: rtl/reg_file_scoreboard.sv
// Register bank with two combinational read ports, one write port and a per-register
// busy scoreboard; write and mark enables are active-low, write data bypasses to reads.
module reg_file_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             BUSY1,
    output logic             BUSY2,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             WE,
    input  logic [AW-1:0]    MA,
    input  logic             ME,
    output logic             ANY_BUSY
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_ok;
    logic             mk_ok;
    logic             byp1;
    logic             byp2;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok = !WE && !is_zero(WA);
    assign mk_ok = !ME && !is_zero(MA);

    // A zero-register write is dropped, so it never qualifies for bypass either.
    assign byp1 = wr_ok && (WA == RA1);
    assign byp2 = wr_ok && (WA == RA2);

    // Mark is applied after write so a same-address mark leaves the busy bit set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                data[WA] <= WD;
                busy[WA] <= 1'b0;
            end
            if (mk_ok) begin
                busy[MA] <= 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held, even if a write is being presented.
    assign RD1 = (!RST || is_zero(RA1)) ? '0 : (byp1 ? WD : data[RA1]);
    assign RD2 = (!RST || is_zero(RA2)) ? '0 : (byp2 ? WD : data[RA2]);

    assign BUSY1    = RST && !byp1 && busy[RA1];
    assign BUSY2    = RST && !byp2 && busy[RA2];
    assign ANY_BUSY = RST && (|busy);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed vector table, reset and sweep sequences,
// then randomized traffic checked against an array-based reference model.
module tb_reg_file_scoreboard;

    logic        CLK;
    logic        RST;
    logic [3:0]  RA1, RA2, WA, MA;
    logic [31:0] RD1, RD2, WD;
    logic        BUSY1, BUSY2, WE, ME, ANY_BUSY;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdata [16];
    logic        mbusy [16];

    reg_file_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .BUSY1(BUSY1), .BUSY2(BUSY2),
        .WA(WA), .WD(WD), .WE(WE),
        .MA(MA), .ME(ME), .ANY_BUSY(ANY_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        me;
        logic [3:0]  ma;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        any;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mdata[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Register 0 is hard-wired: writes and marks to it are dropped.
    task automatic model_update();
        if (!WE && WA != 0) begin
            mdata[WA] = WD;
            mbusy[WA] = 1'b0;
        end
        if (!ME && MA != 0) mbusy[MA] = 1'b1;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] ra);
        if (ra == 0) return '0;
        if (!WE && WA == ra) return WD;
        return mdata[ra];
    endfunction

    function automatic logic model_busy(input logic [3:0] ra);
        if (ra != 0 && !WE && WA == ra) return 1'b0;
        return mbusy[ra];
    endfunction

    function automatic logic model_any();
        logic r = 1'b0;
        for (int i = 0; i < 16; i++) r |= mbusy[i];
        return r;
    endfunction

    task automatic idle();
        WE = 1'b1; ME = 1'b1; WA = '0; MA = '0; WD = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_update();
        #1;
    endtask

    initial begin
        //          we    wa  wd            me    ma  ra1 ra2 rd1           rd2           b1    b2    any
        vecs[0]  = '{1'b0, 3, 32'h12345678, 1'b1, 0, 3, 0, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 0, 32'h0,        1'b1, 0, 3, 0, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 0, 32'hFFFFFFFF, 1'b1, 0, 3, 0, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 0, 32'h0,        1'b1, 0, 0, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 0, 32'h0,        1'b0, 4, 4, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 0, 32'h0,        1'b1, 0, 4, 0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 0, 32'h0,        1'b1, 0, 4, 4, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4, 32'hA5,       1'b1, 0, 4, 0, 32'hA5,       32'h0,        1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 0, 32'h0,        1'b1, 0, 4, 0, 32'hA5,       32'h0,        1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 0, 32'h0,        1'b0, 9, 9, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 0, 32'h0,        1'b1, 0, 9, 0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 9, 32'h55,       1'b0, 9, 9, 9, 32'h55,       32'h55,       1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 0, 32'h0,        1'b1, 0, 9, 9, 32'h55,       32'h55,       1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 6, 32'h77,       1'b1, 0, 6, 6, 32'h77,       32'h77,       1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 6, 32'h0,        1'b1, 0, 6, 6, 32'h77,       32'h77,       1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 9, 32'h56,       1'b1, 0, 9, 6, 32'h56,       32'h77,       1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 0, 32'h0,        1'b1, 0, 9, 6, 32'h56,       32'h77,       1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 0, 32'h0,        1'b0, 0, 0, 9, 32'h0,        32'h56,       1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 0, 32'h0,        1'b1, 0, 0, 9, 32'h0,        32'h56,       1'b0, 1'b0, 1'b0};

        // Reset held with an active write presented: outputs must stay 0.
        model_reset();
        RST = 1'b0;
        idle();
        WE = 1'b0; WA = 3; WD = 32'hCAFEF00D; RA1 = 3; RA2 = 3;
        #2;
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_rd2", RD2, 32'h0);
        chk("reset_any", {31'b0, ANY_BUSY}, 32'h0);
        idle();
        @(negedge CLK);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            WE = vecs[i].we; WA = vecs[i].wa; WD = vecs[i].wd;
            ME = vecs[i].me; MA = vecs[i].ma;
            RA1 = vecs[i].ra1; RA2 = vecs[i].ra2;
            @(negedge CLK);
            chk($sformatf("vec%0d_rd1", i), RD1, vecs[i].rd1);
            chk($sformatf("vec%0d_rd2", i), RD2, vecs[i].rd2);
            chk($sformatf("vec%0d_busy1", i), {31'b0, BUSY1}, {31'b0, vecs[i].b1});
            chk($sformatf("vec%0d_busy2", i), {31'b0, BUSY2}, {31'b0, vecs[i].b2});
            chk($sformatf("vec%0d_any", i), {31'b0, ANY_BUSY}, {31'b0, vecs[i].any});
            tick();
        end

        // Mid-cycle asynchronous reset after writing r5 and marking r7.
        idle();
        WE = 1'b0; WA = 5; WD = 32'hDEADBEEF; ME = 1'b0; MA = 7;
        tick();
        WE = 1'b0; WA = 5; WD = 32'h1234; ME = 1'b1; RA1 = 5; RA2 = 7;
        #2;
        chk("pre_rst_busy7", {31'b0, BUSY2}, 32'h1);
        RST = 1'b0;
        model_reset();
        #1;
        chk("midrst_rd1", RD1, 32'h0);
        chk("midrst_any", {31'b0, ANY_BUSY}, 32'h0);
        chk("midrst_busy2", {31'b0, BUSY2}, 32'h0);
        idle();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("postrst_r5", RD1, 32'h0);
        chk("postrst_busy7", {31'b0, BUSY2}, 32'h0);
        tick();

        // Full sweep: mark r1..r15, then retire them one by one.
        for (int i = 1; i < 16; i++) begin
            idle();
            ME = 1'b0; MA = 4'(i);
            @(negedge CLK);
            chk($sformatf("sweep_mark%0d_any", i), {31'b0, ANY_BUSY}, (i == 1) ? 32'h0 : 32'h1);
            tick();
        end
        for (int i = 1; i < 16; i++) begin
            idle();
            WE = 1'b0; WA = 4'(i); WD = 32'(i); RA1 = 4'(i); RA2 = 4'(i);
            @(negedge CLK);
            chk($sformatf("sweep_wr%0d_any", i), {31'b0, ANY_BUSY}, 32'h1);
            chk($sformatf("sweep_wr%0d_rd1", i), RD1, 32'(i));
            chk($sformatf("sweep_wr%0d_busy2", i), {31'b0, BUSY2}, 32'h0);
            tick();
        end
        idle();
        for (int j = 1; j < 16; j++) begin
            RA1 = 4'(j); RA2 = 4'(16 - j);
            @(negedge CLK);
            if (j == 1) chk("sweep_any_clear", {31'b0, ANY_BUSY}, 32'h0);
            chk($sformatf("sweep_rd1_r%0d", j), RD1, 32'(j));
            chk($sformatf("sweep_rd2_r%0d", 16 - j), RD2, 32'(16 - j));
            tick();
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            WE  = ($urandom_range(0, 2) != 0);
            ME  = ($urandom_range(0, 3) != 0);
            WA  = 4'($urandom_range(0, 15));
            MA  = ($urandom_range(0, 4) == 0) ? WA : 4'($urandom_range(0, 15));
            WD  = $urandom;
            RA1 = 4'($urandom_range(0, 15));
            RA2 = ($urandom_range(0, 3) == 0) ? WA : 4'($urandom_range(0, 15));
            @(negedge CLK);
            chk("rand_rd1", RD1, model_rd(RA1));
            chk("rand_rd2", RD2, model_rd(RA2));
            chk("rand_busy1", {31'b0, BUSY1}, {31'b0, model_busy(RA1)});
            chk("rand_busy2", {31'b0, BUSY2}, {31'b0, model_busy(RA2)});
            chk("rand_any", {31'b0, ANY_BUSY}, {31'b0, model_any()});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
